han_carlson_pipelined_addsub: RTL and testbench
===============================================

// Module: han_carlson_pipelined_addsub
// PURPOSE
//  Parametrised, fully pipelined Han-Carlson parallel-prefix adder/subtractor with valid/ready flow control.
//  - Prefix network: Brent-Kung odd-bit pre-level, Kogge-Stone sparse levels, Brent-Kung even-bit fix-up level.
//  - One register stage per prefix level.
//  - Adds carry-in, subtract mode, signed overflow and backpressure over the combinational adder.
//  - Sits in the datapath wherever a wide add/sub must close timing at full clock rate.
// PARAMETERS
//  N        64   operand width; power of two, >= 4
//  LATENCY  $clog2(N)+2   derived, do not override; accept-to-output cycles
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operands valid
//  in_ready   out  1  block can accept this cycle
//  in_a       in   N  operand A
//  in_b       in   N  operand B
//  in_cin     in   1  carry-in (ignored when in_sub=1)
//  in_sub     in   1  0: A+B+cin; 1: A-B (A + ~B + 1)
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  out_sum    out  N  result
//  out_cout   out  1  carry-out (for sub: 1 = no borrow)
//  out_ovf    out  1  signed two's-complement overflow
// BEHAVIOUR
//  - Transfer rules:
//    - Input transfer occurs when in_valid && in_ready.
//    - Output transfer occurs when out_valid && out_ready.
//  - Pipeline stages:
//    - S0: register a, b' = b ^ {N{sub}}, c0 = sub ? 1 : cin.
//    - S1: compute p = a^b', g = a&b'; fold c0 into bit 0 (g0 |= p0&c0); run the BK pre-level on odd bits.
//    - S2..S(log2N): KS levels on odd bits, span 2,4,...,N/2.
//    - S(log2N+1): BK fix-up on even bits, then sum = p ^ {G[N-2:0], c0} and cout = G[N-1].
//    - ovf = a[N-1] ~^ b'[N-1] & (a[N-1] ^ sum[N-1]).
//    - Every stage carries its valid bit.
//  - Latency: a result accepted at edge k presents at out_* after edge k+LATENCY (N=64: 8; N=8: 5), absent stalls.
//  - Throughput: 1 op/cycle sustained.
//  - Stall (global):
//    - stall = out_valid && !out_ready.
//    - All stage registers hold while stalled.
//    - in_ready = !stall, combinational.
//    - Bubbles are not compressed.
//  - out_* stay stable while out_valid && !out_ready.
//  - in_valid=0 inserts a bubble (valid=0); data registers may update but out_valid gates use.
//  - Reset:
//    - All valid bits -> 0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
//    - in_ready=1 during and after reset.
//    - Reset mid-operation discards all in-flight ops; no partial result emerges.
//  - Simultaneous accept and emit in the same cycle is legal, with no loss or duplication.
//  - Boundaries:
//    - Add A=all-ones, B=0, cin=1 -> sum=0, cout=1.
//    - Sub A=B -> sum=0, cout=1, ovf=0.
//    - Sub 0-1 -> all-ones, cout=0.
//  - No X propagation from input data when in_valid=0 reaches out_valid.
// CONFIGURATION
//  - HCA_FLAGS_EN defined: adds two output ports, registered with out_sum and with the same reset value 0.
//    - out_zero  out  1  = (out_sum == 0); reduction computed in the final stage, no extra latency.
//    - out_neg   out  1  = out_sum[N-1]
//  - HCA_FLAGS_EN undefined: the ports and the zero-detect logic are absent; all else identical.
// TESTING
//  1. N=8, reset, then add 0x0F+0x01 (cin=0), out_ready=1
//     -> after 5 cycles: sum=0x10, cout=0, ovf=0; in_ready stays 1.
//  2. N=8 add 0x7F+0x01 -> sum=0x80, ovf=1, cout=0.
//     Add 0xFF+0x00 with cin=1 -> sum=0x00, cout=1.
//  3. N=8 sub: 0x05-0x05 -> 0x00, cout=1; 0x00-0x01 -> 0xFF, cout=0; 0x80-0x01 -> 0x7F, ovf=1.
//  4. Stream 20 random ops back-to-back, out_ready=1
//     -> 20 results in order, one per cycle, matching the reference model.
//  5. Backpressure: out_ready=0 for 3 cycles while out_valid=1
//     -> in_ready=0 and out_* stable; no loss/duplication after release (N=64, 100 ops, random stalls).
//  6. Assert rst with 3 ops in flight -> out_valid=0 the next cycle and no stale results afterwards.
//     With HCA_FLAGS_EN: 0x05-0x05 -> out_zero=1, out_neg=0.

Source files
------------

// File: rtl/han_carlson_pipelined_addsub_if.sv
// Operand/result bundle for the Han-Carlson add/sub pipeline.
// HCA_FLAGS_EN adds the out_zero/out_neg result flags.
interface han_carlson_pipelined_addsub_if #(
   parameter int N = 64
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
`ifdef HCA_FLAGS_EN
   logic         out_zero;
   logic         out_neg;
`endif

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
`ifdef HCA_FLAGS_EN
      , output out_zero, out_neg
`endif
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
`ifdef HCA_FLAGS_EN
      , input out_zero, out_neg
`endif
   );
endinterface

// File: rtl/han_carlson_pipelined_addsub.sv
// Pipelined Han-Carlson adder/subtractor, one register per prefix level, global stall on out_ready.
// HCA_FLAGS_EN adds registered out_zero/out_neg flags alongside out_sum.
module han_carlson_pipelined_addsub #(
   parameter int N = 64,
   localparam int LATENCY = $clog2(N) + 2
) (
   input logic                           clk,
   input logic                           rst,
   han_carlson_pipelined_addsub_if.slave bus
);
   localparam int L  = LATENCY - 2;
   localparam int NS = L + 1;

   logic stall;

   logic         s0_vld_q, s0_vld_d;
   logic [N-1:0] s0_a_q, s0_a_d;
   logic [N-1:0] s0_b_q, s0_b_d;
   logic         s0_c0_q, s0_c0_d;

   logic [NS:1]  st_vld_q, st_vld_d;
   logic [NS:1]  st_c0_q, st_c0_d;
   logic [NS:1]  st_amsb_q, st_amsb_d;
   logic [N-1:0] st_p_q [1:NS];
   logic [N-1:0] st_p_d [1:NS];
   logic [N-1:0] st_g_q [1:NS];
   logic [N-1:0] st_g_d [1:NS];
   logic [N-1:0] st_gp_q [1:NS];
   logic [N-1:0] st_gp_d [1:NS];

   logic         out_vld_q, out_vld_d;
   logic [N-1:0] out_sum_q, out_sum_d;
   logic         out_cout_q, out_cout_d;
   logic         out_ovf_q, out_ovf_d;
`ifdef HCA_FLAGS_EN
   logic         out_zero_q, out_zero_d;
   logic         out_neg_q, out_neg_d;
`endif

   logic [N-1:0] p1, g1, sum;

   always_comb begin
      stall    = out_vld_q && !bus.out_ready;

      s0_vld_d = bus.in_valid;
      s0_a_d   = bus.in_a;
      s0_b_d   = bus.in_b ^ {N{bus.in_sub}};
      s0_c0_d  = bus.in_sub | bus.in_cin;

      st_vld_d  = {st_vld_q[NS-1:1], s0_vld_q};
      st_c0_d   = {st_c0_q[NS-1:1], s0_c0_q};
      st_amsb_d = {st_amsb_q[NS-1:1], s0_a_q[N-1]};

      // S1: bit generate/propagate with carry-in folded into bit 0, then odd-bit pre-level
      p1    = s0_a_q ^ s0_b_q;
      g1    = s0_a_q & s0_b_q;
      g1[0] = g1[0] | (p1[0] & s0_c0_q);
      st_p_d[1]  = p1;
      st_g_d[1]  = g1;
      st_gp_d[1] = p1;
      for (int i = 1; i < N; i += 2) begin
         st_g_d[1][i]  = g1[i] | (p1[i] & g1[i-1]);
         st_gp_d[1][i] = p1[i] & p1[i-1];
      end

      // S2..SL: sparse Kogge-Stone on odd bits, span doubling from 2 to N/2
      for (int l = 2; l <= NS; l++) begin
         st_p_d[l]  = st_p_q[l-1];
         st_g_d[l]  = st_g_q[l-1];
         st_gp_d[l] = st_gp_q[l-1];
      end
      for (int l = 2; l <= L; l++) begin
         for (int i = 1; i < N; i += 2) begin
            if (i >= (1 << (l-1))) begin
               st_g_d[l][i]  = st_g_q[l-1][i] | (st_gp_q[l-1][i] & st_g_q[l-1][i-(1 << (l-1))]);
               st_gp_d[l][i] = st_gp_q[l-1][i] & st_gp_q[l-1][i-(1 << (l-1))];
            end
         end
      end

      for (int i = 2; i < N; i += 2) begin
         st_g_d[NS][i] = st_g_q[L][i] | (st_p_q[L][i] & st_g_q[L][i-1]);
      end

      sum        = st_p_q[NS] ^ {st_g_q[NS][N-2:0], st_c0_q[NS]};
      out_vld_d  = st_vld_q[NS];
      out_sum_d  = out_sum_q;
      out_cout_d = out_cout_q;
      out_ovf_d  = out_ovf_q;
`ifdef HCA_FLAGS_EN
      out_zero_d = out_zero_q;
      out_neg_d  = out_neg_q;
`endif
      // Result registers only load on real ops so bubble data never reaches the outputs
      if (st_vld_q[NS]) begin
         out_sum_d  = sum;
         out_cout_d = st_g_q[NS][N-1];
         out_ovf_d  = ~st_p_q[NS][N-1] & (st_amsb_q[NS] ^ sum[N-1]);
`ifdef HCA_FLAGS_EN
         out_zero_d = ~|sum;
         out_neg_d  = sum[N-1];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_vld_q   <= 1'b0;
         s0_a_q     <= '0;
         s0_b_q     <= '0;
         s0_c0_q    <= 1'b0;
         st_vld_q   <= '0;
         st_c0_q    <= '0;
         st_amsb_q  <= '0;
         for (int l = 1; l <= NS; l++) begin
            st_p_q[l]  <= '0;
            st_g_q[l]  <= '0;
            st_gp_q[l] <= '0;
         end
         out_vld_q  <= 1'b0;
         out_sum_q  <= '0;
         out_cout_q <= 1'b0;
         out_ovf_q  <= 1'b0;
`ifdef HCA_FLAGS_EN
         out_zero_q <= 1'b0;
         out_neg_q  <= 1'b0;
`endif
      end else if (!stall) begin
         s0_vld_q   <= s0_vld_d;
         s0_a_q     <= s0_a_d;
         s0_b_q     <= s0_b_d;
         s0_c0_q    <= s0_c0_d;
         st_vld_q   <= st_vld_d;
         st_c0_q    <= st_c0_d;
         st_amsb_q  <= st_amsb_d;
         for (int l = 1; l <= NS; l++) begin
            st_p_q[l]  <= st_p_d[l];
            st_g_q[l]  <= st_g_d[l];
            st_gp_q[l] <= st_gp_d[l];
         end
         out_vld_q  <= out_vld_d;
         out_sum_q  <= out_sum_d;
         out_cout_q <= out_cout_d;
         out_ovf_q  <= out_ovf_d;
`ifdef HCA_FLAGS_EN
         out_zero_q <= out_zero_d;
         out_neg_q  <= out_neg_d;
`endif
      end
   end

   assign bus.in_ready  = !stall;
   assign bus.out_valid = out_vld_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_cout  = out_cout_q;
   assign bus.out_ovf   = out_ovf_q;
`ifdef HCA_FLAGS_EN
   assign bus.out_zero  = out_zero_q;
   assign bus.out_neg   = out_neg_q;
`endif
endmodule

// File: tb/tb_han_carlson_pipelined_addsub.sv
// Directed and streamed checks of the Han-Carlson add/sub pipeline at N=8 and N=64.
module tb_han_carlson_pipelined_addsub;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   han_carlson_pipelined_addsub_if #(.N(8))  if8 ();
   han_carlson_pipelined_addsub_if #(.N(64)) if64 ();

   han_carlson_pipelined_addsub #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
   han_carlson_pipelined_addsub #(.N(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

   function automatic logic [9:0] model8(input logic [7:0] a, b, input logic cin, sub);
      logic [7:0] bb;
      logic [8:0] full;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {8'd0, (sub | cin)};
      return {(a[7] == bb[7]) && (full[7] != a[7]), full[8], full[7:0]};
   endfunction

   function automatic logic [65:0] model64(input logic [63:0] a, b, input logic cin, sub);
      logic [63:0] bb;
      logic [64:0] full;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {64'd0, (sub | cin)};
      return {(a[63] == bb[63]) && (full[63] != a[63]), full[64], full[63:0]};
   endfunction

   task automatic op8(input logic [7:0] a, b, input logic cin, sub,
                      output logic [9:0] res, output int lat, output logic rdy_ok);
      rdy_ok = 1'b1;
      lat    = -1;
      res    = 'x;
      if8.in_a = a; if8.in_b = b; if8.in_cin = cin; if8.in_sub = sub; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (if8.in_ready !== 1'b1) rdy_ok = 1'b0;
         @(posedge clk); #1;
         if (if8.out_valid === 1'b1) begin
            lat = c;
            res = {if8.out_ovf, if8.out_cout, if8.out_sum};
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({if8.out_valid, if8.out_sum, if8.out_cout, if8.out_ovf} !== 11'd0) begin
         fails++;
         $display("FAIL reset_outputs8 got v=%b s=%h c=%b o=%b want all 0", if8.out_valid, if8.out_sum, if8.out_cout, if8.out_ovf);
      end
      tests++;
      if ({if64.out_valid, if64.out_sum, if64.out_cout, if64.out_ovf} !== 67'd0) begin
         fails++;
         $display("FAIL reset_outputs64 got v=%b s=%h want 0 0", if64.out_valid, if64.out_sum);
      end
      tests++;
      if (if8.in_ready !== 1'b1 || if64.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready got %b/%b want 1/1", if8.in_ready, if64.in_ready);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL post_reset got rdy=%b v=%b want 1 0", if8.in_ready, if8.out_valid);
      end
   endtask

   task automatic test_vectors;
      // a, b, cin, sub, {ovf, cout, sum}
      logic [7:0] va [9]   = '{8'h0F, 8'h7F, 8'hFF, 8'h80, 8'h05, 8'h00, 8'h80, 8'h10, 8'h3C};
      logic [7:0] vb [9]   = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h05, 8'h01, 8'h01, 8'h03, 8'h5A};
      logic       vc [9]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       vs [9]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [9:0] vexp [9] = '{{2'b00, 8'h10}, {2'b10, 8'h80}, {2'b01, 8'h00}, {2'b11, 8'h00},
                               {2'b01, 8'h00}, {2'b00, 8'hFF}, {2'b11, 8'h7F}, {2'b01, 8'h0D},
                               {2'b10, 8'h97}};
      logic [9:0] res;
      int         lat;
      logic       rok;
      for (int k = 0; k < 9; k++) begin
         op8(va[k], vb[k], vc[k], vs[k], res, lat, rok);
         tests++;
         if (res !== vexp[k]) begin
            fails++;
            $display("FAIL vec%0d %h %s %h got ovf/cout/sum=%b/%b/%h want %b/%b/%h", k, va[k], vs[k] ? "-" : "+", vb[k],
                     res[9], res[8], res[7:0], vexp[k][9], vexp[k][8], vexp[k][7:0]);
         end
         tests++;
         if (lat !== 5) begin
            fails++;
            $display("FAIL latency%0d got %0d want 5", k, lat);
         end
         tests++;
         if (rok !== 1'b1) begin
            fails++;
            $display("FAIL in_ready%0d got 0 want 1", k);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] q[$];
      logic [9:0] exp_v;
      logic [7:0] a, b;
      logic       cin, sub;
      int         got = 0, first = -1, last = -1;
      for (int c = 0; c < 40; c++) begin
         if (c < 20) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            if8.in_a = a; if8.in_b = b; if8.in_cin = cin; if8.in_sub = sub; if8.in_valid = 1'b1;
            q.push_back(model8(a, b, cin, sub));
         end else begin
            if8.in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (if8.out_valid === 1'b1) begin
            exp_v = (q.size() > 0) ? q.pop_front() : 10'bx;
            tests++;
            if ({if8.out_ovf, if8.out_cout, if8.out_sum} !== exp_v) begin
               fails++;
               $display("FAIL stream%0d got %b/%b/%h want %b/%b/%h", got, if8.out_ovf, if8.out_cout, if8.out_sum,
                        exp_v[9], exp_v[8], exp_v[7:0]);
            end
            if (first < 0) first = c;
            last = c;
            got++;
         end
      end
      tests++;
      if (got !== 20 || (last - first) !== 19) begin
         fails++;
         $display("FAIL stream_count got %0d results over %0d cycles want 20 over 20", got, last - first + 1);
      end
   endtask

   task automatic test_backpressure;
      logic [65:0] q[$];
      logic [65:0] exp_v, held_val, cur;
      logic [63:0] a, b;
      logic        cin, sub, held_vld;
      int          seen, sent, got, cyc;
      // Two ops in flight; the first is held at the output for 3 cycles
      if64.out_ready = 1'b0;
      if64.in_a = '1; if64.in_b = '0; if64.in_cin = 1'b1; if64.in_sub = 1'b0; if64.in_valid = 1'b1;
      @(posedge clk); #1;
      if64.in_a = 64'd1; if64.in_b = 64'd2; if64.in_cin = 1'b0;
      @(posedge clk); #1;
      if64.in_valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (if64.out_valid === 1'b1) seen = 1;
      end
      for (int c = 0; c < 3; c++) begin
         tests++;
         if (!seen || if64.in_ready !== 1'b0 || if64.out_valid !== 1'b1 || if64.out_sum !== 64'd0 || if64.out_cout !== 1'b1) begin
            fails++;
            $display("FAIL stall_hold%0d got rdy=%b v=%b s=%h c=%b want 0 1 0 1", c, if64.in_ready, if64.out_valid, if64.out_sum, if64.out_cout);
         end
         @(posedge clk); #1;
      end
      if64.out_ready = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (if64.out_valid !== 1'b1 || if64.out_sum !== 64'd3 || if64.out_cout !== 1'b0) begin
         fails++;
         $display("FAIL stall_release got v=%b s=%h c=%b want 1 3 0", if64.out_valid, if64.out_sum, if64.out_cout);
      end
      @(posedge clk); #1;
      tests++;
      if (if64.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL stall_nodup got v=%b want 0", if64.out_valid);
      end

      sent = 0; got = 0; cyc = 0; held_vld = 1'b0; held_val = '0;
      while (got < 100 && cyc < 5000) begin
         cur = {if64.out_ovf, if64.out_cout, if64.out_sum};
         if (held_vld) begin
            tests++;
            if (if64.out_valid !== 1'b1 || cur !== held_val) begin
               fails++;
               $display("FAIL stall_stable cyc%0d got v=%b %h want 1 %h", cyc, if64.out_valid, cur, held_val);
            end
         end
         if64.out_ready = ($urandom_range(0, 3) != 0);
         if (sent < 100 && $urandom_range(0, 4) != 0) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); sub = 1'($urandom);
            if64.in_a = a; if64.in_b = b; if64.in_cin = cin; if64.in_sub = sub; if64.in_valid = 1'b1;
         end else begin
            if64.in_valid = 1'b0;
         end
         #1;
         if (if64.in_valid && if64.in_ready === 1'b1) begin
            q.push_back(model64(a, b, cin, sub));
            sent++;
         end
         if (if64.out_valid === 1'b1 && if64.out_ready) begin
            exp_v = (q.size() > 0) ? q.pop_front() : 66'bx;
            tests++;
            if (cur !== exp_v) begin
               fails++;
               $display("FAIL random%0d got %h want %h", got, cur, exp_v);
            end
            got++;
         end
         held_vld = (if64.out_valid === 1'b1) && !if64.out_ready;
         held_val = cur;
         @(posedge clk); #1;
         cyc++;
      end
      if64.in_valid = 1'b0;
      if64.out_ready = 1'b1;
      tests++;
      if (got !== 100 || q.size() !== 0) begin
         fails++;
         $display("FAIL random_count got %0d left %0d want 100 0", got, q.size());
      end
   endtask

   task automatic test_reset_midflight;
      int stray = 0;
      if8.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if8.in_a = 8'(k + 1); if8.in_b = 8'h20; if8.in_cin = 1'b0; if8.in_sub = 1'b0; if8.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      if8.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL midflight_reset got v=%b rdy=%b want 0 1", if8.out_valid, if8.in_ready);
      end
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (if8.out_valid !== 1'b0) stray++;
      end
      tests++;
      if (stray !== 0) begin
         fails++;
         $display("FAIL midflight_stale got %0d stale results want 0", stray);
      end
   endtask

`ifdef HCA_FLAGS_EN
   task automatic test_flags;
      logic [9:0] res;
      int         lat;
      logic       rok;
      op8(8'h05, 8'h05, 1'b0, 1'b1, res, lat, rok);
      tests++;
      if (if8.out_zero !== 1'b1 || if8.out_neg !== 1'b0) begin
         fails++;
         $display("FAIL flags_zero got zero=%b neg=%b want 1 0", if8.out_zero, if8.out_neg);
      end
      op8(8'h00, 8'h01, 1'b0, 1'b1, res, lat, rok);
      tests++;
      if (if8.out_zero !== 1'b0 || if8.out_neg !== 1'b1) begin
         fails++;
         $display("FAIL flags_neg got zero=%b neg=%b want 0 1", if8.out_zero, if8.out_neg);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      if8.in_valid = 1'b0;  if8.in_a = '0;  if8.in_b = '0;  if8.in_cin = 1'b0;  if8.in_sub = 1'b0;  if8.out_ready = 1'b1;
      if64.in_valid = 1'b0; if64.in_a = '0; if64.in_b = '0; if64.in_cin = 1'b0; if64.in_sub = 1'b0; if64.out_ready = 1'b1;
      test_reset;
      test_vectors;
      test_back_to_back;
      test_backpressure;
      test_reset_midflight;
`ifdef HCA_FLAGS_EN
      test_flags;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout after %0d tests", tests);
      $fatal(1, "watchdog");
   end
endmodule
